// File: rtl/id_ex_skid.sv
// Decode-to-execute pipeline boundary with a 2-entry skid buffer.
// in_ready comes from a flop, so it never depends combinationally on out_ready.
module id_ex_skid #(
  parameter int              XLEN = 32,
  parameter int              OH_W = 7,
  parameter logic [XLEN-1:0] NOP  = 'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_op1,
  input  logic [XLEN-1:0] in_op2,
  input  logic [XLEN-1:0] in_ins,
  input  logic [XLEN-1:0] in_ins_addr,
  input  logic [4:0]      in_rd_addr,
  input  logic            in_rd_wen,
  input  logic [OH_W-1:0] in_oh,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_ins,
  output logic [XLEN-1:0] out_ins_addr,
  output logic [4:0]      out_rd_addr,
  output logic            out_rd_wen,
  output logic [OH_W-1:0] out_oh
);

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] ins_addr;
    logic [4:0]      rd_addr;
    logic            rd_wen;
    logic [OH_W-1:0] oh;
  } pay_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam pay_t RST_PAY = '{
    op1:      '0,
    op2:      '0,
    ins:      NOP,
    ins_addr: '0,
    rd_addr:  '0,
    rd_wen:   1'b0,
    oh:       '0
  };

  state_t state_q;
  state_t state_d;
  pay_t   main_q;
  pay_t   skid_q;
  pay_t   in_pay;
  logic   in_ready_q;
  logic   out_valid_q;
  logic   accept;
  logic   pop;
  logic   ld_main_in;
  logic   ld_main_skid;
  logic   ld_skid;

  assign in_pay = '{
    op1:      in_op1,
    op2:      in_op2,
    ins:      in_ins,
    ins_addr: in_ins_addr,
    rd_addr:  in_rd_addr,
    rd_wen:   in_rd_wen,
    oh:       in_oh
  };

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid_q & out_ready;

  // Flush leaves payload untouched; only the state is squashed.
  assign ld_main_in   = ~flush & accept
                      & ((state_q == EMPTY) | pop);
  assign ld_skid      = ~flush & accept & ~pop
                      & (state_q == FULL);
  assign ld_main_skid = ~flush & pop
                      & (state_q == SKID);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        unique case (1'b1)
          pop & ~accept: state_d = EMPTY;
          ~pop & accept: state_d = SKID;
          default:       state_d = FULL;
        endcase
      end
      SKID: begin
        if (pop) state_d = FULL;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= RST_PAY;
      skid_q      <= RST_PAY;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != SKID);
      out_valid_q <= (state_d != EMPTY);
      if (ld_main_in)   main_q <= in_pay;
      if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)      skid_q <= in_pay;
    end
  end

  assign out_op1      = main_q.op1;
  assign out_op2      = main_q.op2;
  assign out_ins      = main_q.ins;
  assign out_ins_addr = main_q.ins_addr;
  assign out_rd_addr  = main_q.rd_addr;
  // Execute sees a no-op whenever nothing is held.
  assign out_rd_wen   = main_q.rd_wen & out_valid_q;
  assign out_oh       = out_valid_q ? main_q.oh : '0;

endmodule
